// File: rtl/button_conditioner.sv
// Five-button front end: per-button 2-flop sync + debounce FSM, then a locking
// one-hot direction arbiter (right > left > up > down) and a center press strobe.

module btn_debounce #(
  parameter int DBNC_CYCLES = 500000,
  parameter int CNT_W       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic accept
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DBNC_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], raw};
  end

  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt clears on every wait-state entry and stops at CNT_MAX, so it cannot wrap
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s)                 state_nxt = IDLE;
        else if (cnt == CNT_MAX) state_nxt = HELD;
        else                    cnt_nxt   = cnt + 1'b1;
      end
      HELD: begin
        if (!s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s)                   state_nxt = HELD;
        else if (cnt == CNT_MAX) state_nxt = IDLE;
        else                     cnt_nxt   = cnt + 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    level  = (state == HELD) || (state == RELEASE_WAIT);
    accept = (state == PRESS_WAIT) && s && (cnt == CNT_MAX);
  end

endmodule

module button_conditioner #(
  parameter int DBNC_CYCLES = 500000,
  parameter int CNT_W       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_center,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic center_pulse,
  output logic any_pressed
);

  localparam int NUM_BTN = 5;
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_CENTER = 4;

  logic [NUM_BTN-1:0] raw, lvl, acc;
  logic [3:0]         grant, grant_nxt;
  logic               cpulse_q;

  assign raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

  btn_debounce #(
    .DBNC_CYCLES(DBNC_CYCLES),
    .CNT_W      (CNT_W)
  ) u_lane [NUM_BTN-1:0] (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw),
    .level (lvl),
    .accept(acc)
  );

  // grant bits share lane indices 0..3; a release clears first, re-arbitration next edge
  always_comb begin
    grant_nxt = grant;
    if (grant == 4'b0000) begin
      if      (lvl[B_RIGHT]) grant_nxt = 4'b1000;
      else if (lvl[B_LEFT])  grant_nxt = 4'b0100;
      else if (lvl[B_UP])    grant_nxt = 4'b0001;
      else if (lvl[B_DOWN])  grant_nxt = 4'b0010;
    end else if ((grant & lvl[3:0]) == 4'b0000) begin
      grant_nxt = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant    <= '0;
      cpulse_q <= 1'b0;
    end else begin
      grant    <= grant_nxt;
      cpulse_q <= acc[B_CENTER];
    end
  end

  assign up           = grant[B_UP];
  assign down         = grant[B_DOWN];
  assign left         = grant[B_LEFT];
  assign right        = grant[B_RIGHT];
  assign center_pulse = cpulse_q;
  assign any_pressed  = |lvl;

endmodule
